// File: rtl/multi_digit_display_ctrl.sv
// rtl/multi_digit_display_ctrl.sv - N-digit multiplexed 7-segment controller with serial binary-to-BCD
// Optional breathing LED when DISP_BREATH_EN is defined.
module multi_digit_display_ctrl #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int NUM_DIGITS  = 6,
    parameter int DATA_W      = 20,
    parameter int REFRESH_DIV = 50_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_value,
    input  logic [3:0]            brightness,
    input  logic                  lz_blank,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic                  ovf,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] an_out,
    output logic                  breath_led
);
    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int CNT_W  = $clog2(DATA_W + 1);

    function automatic logic [39:0] max_value(input int n);
        logic [39:0] p;
        p = 40'd1;
        for (int i = 0; i < n; i++) p = p * 40'd10;
        return p - 40'd1;
    endfunction

    localparam logic [39:0] MAX_VALUE = max_value(NUM_DIGITS);

    typedef enum logic {S_IDLE, S_CONV} state_t;
    state_t state_q, state_d;

    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_pend_q;
    logic [BCD_W-1:0]  disp_bcd_q;
    logic              disp_ovf_q;
    logic              last_shift;

    assign last_shift = (cnt_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_CONV;
            S_CONV:  if (last_shift) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_IDLE);
    end

    // Double-dabble step: add 3 to any nibble >= 5, then shift one binary bit in.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_adj[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_adj[4*k +: 4] + 4'd3;
        end
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
        bin_d = {bin_q[DATA_W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            disp_bcd_q <= '0;
            disp_ovf_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    bin_q      <= in_value;
                    bcd_q      <= '0;
                    cnt_q      <= '0;
                    ovf_pend_q <= (40'(in_value) > MAX_VALUE);
                end
                S_CONV: begin
                    bin_q <= bin_d;
                    bcd_q <= bcd_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_shift) begin
                        disp_bcd_q <= bcd_d;
                        disp_ovf_q <= ovf_pend_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ovf = disp_ovf_q;

    logic [SLOT_W-1:0] slot_q;
    logic [IDX_W-1:0]  idx_q;
    logic [3:0]        phase_q;
    logic [3:0]        bright_q;

    // Brightness is only re-sampled at slot boundaries so a digit never changes duty mid-slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q   <= '0;
            idx_q    <= '0;
            phase_q  <= '0;
            bright_q <= '0;
        end else begin
            phase_q <= (phase_q == 4'd14) ? 4'd0 : phase_q + 4'd1;
            if (slot_q == SLOT_W'(REFRESH_DIV - 1)) begin
                slot_q   <= '0;
                bright_q <= brightness;
                idx_q    <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                slot_q <= slot_q + SLOT_W'(1);
            end
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    logic [NUM_DIGITS-1:0] upper_zero;
    logic                  all_zero;
    logic [3:0]            cur_digit;
    logic                  gate_open;
    logic                  blank;
    logic [6:0]            seg_body;

    always_comb begin
        all_zero = 1'b1;
        upper_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero      = all_zero & (disp_bcd_q[4*k +: 4] == 4'd0);
            upper_zero[k] = all_zero;
        end
        cur_digit = disp_bcd_q[{idx_q, 2'b00} +: 4];
        gate_open = (phase_q < bright_q);
        blank     = lz_blank && (idx_q != '0) && upper_zero[idx_q];
        if (disp_ovf_q) seg_body = 7'h3F;
        else if (blank) seg_body = 7'h7F;
        else            seg_body = seg_decode(cur_digit);
        an_out  = '1;
        seg_out = 8'hFF;
        if (gate_open) begin
            an_out[idx_q] = 1'b0;
            seg_out       = {~dp_mask[idx_q], seg_body};
        end
    end

`ifdef DISP_BREATH_EN
    localparam int STEP_DIV = CLK_FREQ_HZ / 100;
    localparam int STEP_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [6:0]        pwm_q;
    logic [6:0]        duty_q;
    logic [STEP_W-1:0] step_q;
    logic              down_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q  <= '0;
            duty_q <= '0;
            step_q <= '0;
            down_q <= 1'b0;
        end else begin
            pwm_q <= (pwm_q == 7'd99) ? 7'd0 : pwm_q + 7'd1;
            if (step_q == STEP_W'(STEP_DIV - 1)) begin
                step_q <= '0;
                if (!down_q) begin
                    duty_q <= duty_q + 7'd1;
                    if (duty_q == 7'd99) down_q <= 1'b1;
                end else begin
                    duty_q <= duty_q - 7'd1;
                    if (duty_q == 7'd1) down_q <= 1'b0;
                end
            end else begin
                step_q <= step_q + STEP_W'(1);
            end
        end
    end

    assign breath_led = (pwm_q < duty_q);
`else
    assign breath_led = 1'b0;
`endif
endmodule

// File: tb/tb_multi_digit_display_ctrl.sv
// tb/tb_multi_digit_display_ctrl.sv - directed bench for multi_digit_display_ctrl
module tb_multi_digit_display_ctrl;
    localparam int ND = 4;
    localparam int DW = 14;
    localparam int RD = 16;
    localparam int CF = 10_000;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_value;
    logic [3:0]    brightness;
    logic          lz_blank;
    logic [ND-1:0] dp_mask;
    logic          ovf;
    logic [7:0]    seg_out;
    logic [ND-1:0] an_out;
    logic          breath_led;

    int tests = 0;
    int fails = 0;

    multi_digit_display_ctrl #(
        .CLK_FREQ_HZ(CF), .NUM_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .brightness(brightness), .lz_blank(lz_blank),
        .dp_mask(dp_mask), .ovf(ovf), .seg_out(seg_out), .an_out(an_out),
        .breath_led(breath_led)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int         value;
        bit         lz;
        logic [3:0] dp;
        int         digit;
        logic [7:0] seg;
        bit         ovf;
    } vec_t;

    vec_t vecs[20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_digit(input string name, input int d, input logic [7:0] exp);
        logic [ND-1:0] want;
        int n;
        want = ~(ND'(1) << d);
        n = 0;
        while (an_out !== want && n < 300) begin
            tick();
            n++;
        end
        if (an_out !== want) begin
            tests++;
            fails++;
            $display("FAIL %s: anode pattern %b never seen, last %b", name, want, an_out);
        end else begin
            check(name, 32'(seg_out), 32'(exp));
        end
    endtask

    task automatic load(input int v);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("load_ready", 32'(in_ready), 32'd1);
        in_value = DW'(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (16) tick();
    endtask

    initial begin
        int last_val;
        int lows, early, open, n;
        logic [ND-1:0] prev;

        vecs[0]  = '{1234,  0, 4'b0000, 0, 8'h99, 0};
        vecs[1]  = '{1234,  0, 4'b0000, 1, 8'hB0, 0};
        vecs[2]  = '{1234,  0, 4'b0000, 2, 8'hA4, 0};
        vecs[3]  = '{1234,  0, 4'b0000, 3, 8'hF9, 0};
        vecs[4]  = '{42,    1, 4'b0000, 2, 8'hFF, 0};
        vecs[5]  = '{42,    1, 4'b0000, 3, 8'hFF, 0};
        vecs[6]  = '{42,    1, 4'b0000, 0, 8'hA4, 0};
        vecs[7]  = '{42,    0, 4'b0000, 2, 8'hC0, 0};
        vecs[8]  = '{42,    0, 4'b0001, 0, 8'h24, 0};
        vecs[9]  = '{42,    0, 4'b0010, 1, 8'h19, 0};
        vecs[10] = '{42,    1, 4'b1000, 3, 8'h7F, 0};
        vecs[11] = '{10000, 0, 4'b0000, 0, 8'hBF, 1};
        vecs[12] = '{10000, 1, 4'b0000, 3, 8'hBF, 1};
        vecs[13] = '{9999,  0, 4'b0000, 3, 8'h90, 0};
        vecs[14] = '{16383, 0, 4'b0000, 2, 8'hBF, 1};
        vecs[15] = '{0,     1, 4'b0000, 0, 8'hC0, 0};
        vecs[16] = '{0,     1, 4'b0000, 1, 8'hFF, 0};
        vecs[17] = '{507,   1, 4'b0000, 1, 8'hC0, 0};
        vecs[18] = '{507,   1, 4'b0000, 2, 8'h92, 0};
        vecs[19] = '{507,   1, 4'b0000, 3, 8'hFF, 0};

        rst = 1'b1; in_valid = 1'b0; in_value = '0; brightness = 4'd15;
        lz_blank = 1'b0; dp_mask = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_an", 32'(an_out), 32'hF);
        check("rst_seg", 32'(seg_out), 32'hFF);
        check("rst_breath", 32'(breath_led), 32'd0);
        check_digit("rst_digit0", 0, 8'hC0);

        last_val = -1;
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].value != last_val) begin
                load(vecs[i].value);
                last_val = vecs[i].value;
            end
            lz_blank = vecs[i].lz;
            dp_mask  = vecs[i].dp;
            check_digit($sformatf("vec%0d_seg", i), vecs[i].digit, vecs[i].seg);
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
        end
        lz_blank = 1'b0;
        dp_mask  = '0;

        // Accept-to-update latency, with stray in_valid pulses during conversion.
        in_value = DW'(10000);
        in_valid = 1'b1;
        tick();
        lows = 0; early = 0;
        for (int k = 1; k <= 14; k++) begin
            if (!in_ready) lows++;
            if (ovf) early++;
            in_valid = (k == 3 || k == 7);
            in_value = '0;
            tick();
        end
        check("conv_busy_cycles", 32'(lows), 32'd14);
        check("conv_no_early_update", 32'(early), 32'd0);
        check("conv_ready_after", 32'(in_ready), 32'd1);
        check("conv_ovf_after", 32'(ovf), 32'd1);
        check_digit("conv_dash_d0", 0, 8'hBF);

        brightness = 4'd0;
        repeat (20) tick();
        open = 0;
        repeat (64) begin
            if (an_out !== '1) open++;
            tick();
        end
        check("bright0_open", 32'(open), 32'd0);

        brightness = 4'd8;
        repeat (20) tick();
        open = 0;
        repeat (240) begin
            if (an_out !== '1) open++;
            tick();
        end
        check("bright8_open", 32'(open), 32'd128);

        brightness = 4'd15;
        repeat (20) tick();
        prev = an_out;
        n = 0;
        while (an_out === prev && n < 40) begin
            tick();
            n++;
        end
        check("slot_edge_found", 32'(n < 40), 32'd1);
        repeat (4) tick();
        brightness = 4'd0;
        open = 0;
        repeat (12) begin
            if (an_out !== '1) open++;
            tick();
        end
        check("midslot_still_open", 32'(open), 32'd12);
        open = 0;
        repeat (16) begin
            if (an_out !== '1) open++;
            tick();
        end
        check("next_slot_dark", 32'(open), 32'd0);
        brightness = 4'd15;

        // Reset during conversion: the captured value must never reach the display.
        in_value = DW'(10000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstconv_ready", 32'(in_ready), 32'd1);
        check("rstconv_ovf", 32'(ovf), 32'd0);
        repeat (20) tick();
        check("rstconv_no_late_ovf", 32'(ovf), 32'd0);
        check_digit("rstconv_d3_zero", 3, 8'hC0);

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
`ifdef DISP_BREATH_EN
        for (int w = 0; w < 3; w++) begin
            open = 0;
            repeat (100) begin
                if (breath_led) open++;
                tick();
            end
            check($sformatf("breath_win%0d", w), 32'(open), 32'(w));
        end
`else
        open = 0;
        repeat (300) begin
            if (breath_led) open++;
            tick();
        end
        check("breath_off", 32'(open), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
